stream_prog_loader: RTL
=======================

# stream_prog_loader

Parametrised program loader that takes a valid/ready word stream and writes it into instruction memory (multi-word lines) and data memory (single words). It holds the core in reset through `prog_loading` until an end-of-program header arrives. It sits in `top` between the host-side stream source (UART receiver or testbench) and the `imem_ld`/`dmem` write ports. It drives the same `prog_loading` mux selects that currently steer memory address, write-enable and write data away from the core.

## Interface
- `WORD_LEN`, 32: stream word and dmem data width.
- `LINE_WORDS`, 4: words per imem line; imem line width is `LINE_WORDS*WORD_LEN`. Must be a power of 2.
- `ADDR_LEN`, 32: byte address width.
- `IMEM_ADDR_LEN`, 9: imem line index width.
- `CNT_LEN`, 16: frame word-count field width.
- `PAD_WORD`, 32'h00000013: fill for unwritten slots of a partial imem line (`addi x0,x0,0`).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: stream word valid.
- `in_data` in `WORD_LEN`: stream word.
- `in_ready` out 1: loader accepts a word this cycle.
- `reload` in 1: single-cycle pulse; restarts loading from the DONE state.
- `prog_loading` out 1: high from reset until DONE is reached.
- `imem_we` out 1: imem line write strobe.
- `imem_addr` out `IMEM_ADDR_LEN`: imem line index.
- `imem_wdata` out `LINE_WORDS*WORD_LEN`: imem line data.
- `dmem_we` out 1: dmem word write strobe.
- `dmem_addr` out `ADDR_LEN`: dmem byte address.
- `dmem_wdata` out `WORD_LEN`: dmem word data.
- `done` out 1: high while in DONE.
- `err` out 1: sticky misalignment error flag.

## Operation
- **Stream format.** A stream is a sequence of frames.
  - Header word: bit31 = END; bit30 = TGT (0 = imem, 1 = dmem); `[CNT_LEN-1:0]` = word count N.
  - Non-END header: followed by one base byte-address word, then N data words.
- **States.**
  - HDR: on accepted word, END=1 → DONE; otherwise latch TGT and N → ADDR.
  - ADDR: on accepted word, latch base address.
    - N=0 → HDR.
    - Otherwise → DATA.
    - An imem base not aligned to `LINE_WORDS*4` bytes sets `err` and marks the frame discard. The frame is still consumed, but no writes are issued.
  - DATA: each accepted word decrements the remaining count.
    - Dmem target: write to base + 4·k.
    - Imem target: the word goes into line slot k mod `LINE_WORDS`. Slot 0 is the MSB slice `[LINE_WORDS*WORD_LEN-1 -: WORD_LEN]`. Filling the last slot issues a line write.
    - After the final word: if the imem line is partially filled → FLUSH; otherwise → HDR.
  - FLUSH: one cycle, `in_ready`=0. Unfilled slots are written with `PAD_WORD`, the line write is issued, then → HDR.
  - DONE: `prog_loading`=0, `done`=1, `in_ready`=0. A `reload` pulse → HDR with `prog_loading`=1; `err` is cleared on reload.
- **Imem line index.** Base byte address >> log2(`LINE_WORDS*4`), incremented per line written, truncated to `IMEM_ADDR_LEN` (wraps silently).
- **Dmem address.** Increments modulo 2^`ADDR_LEN`.
- **Discard frame.** Words are accepted normally; `imem_we` and `dmem_we` stay 0.

## Timing
- Reset values:
  - State HDR, `prog_loading`=1, `in_ready`=1.
  - `done`=0, `err`=0, `imem_we`=0, `dmem_we`=0.
  - All address and data outputs 0; partial line discarded.
- `in_ready`=1 in HDR/ADDR/DATA, 0 in FLUSH/DONE. A word transfers when `in_valid`&`in_ready` at a rising edge.
- Write strobes are registered:
  - `dmem_we` is high for exactly one cycle, in the cycle after the data word is accepted, with address and data valid in that same cycle.
  - `imem_we` follows the same rule after the last-slot word, or in the cycle after FLUSH.
- The stream sustains 1 word/cycle except for the FLUSH bubble.
- `prog_loading` falls in the cycle after the END header is accepted. Any write pending from the preceding frame completes no later than that cycle.
- `reload` outside DONE is ignored.
- An asynchronous `reset` mid-frame aborts the frame and drops any partial line without writing it.

## Structure
- Shared package `prog_loader_pkg` holds:
  - the state enum (HDR, ADDR, DATA, FLUSH, DONE);
  - header bit positions (END=31, TGT=30);
  - `PAD_WORD` default.
- Sub-module `line_packer` holds the line assembly:
  - `LINE_WORDS`-slot register, slot counter, pad-and-emit on flush, clear on reset;
  - outputs the full line and a `line_full` strobe.

## Test plan
- Imem frame {0x00000004, 0x00000000, w0..w3}, then END 0x80000000 → `imem_we`=1 once, `imem_addr`=0, `imem_wdata`={w0,w1,w2,w3}; `prog_loading` falls one cycle after END is accepted; `done`=1.
- Imem frame N=6 at base 0x20 → line 2 = {w0..w3}, then FLUSH bubble with `in_ready`=0, then line 3 = {w4,w5,0x13,0x13}.
- Dmem frame {0x40000002, 0x00000100, 0xDEADBEEF, 0x12345678} → two `dmem_we` pulses: 0x100←0xDEADBEEF, then 0x104←0x12345678.
- Imem base 0x04 with N=4 → `err`=1, 6 words accepted, no `imem_we`; a following aligned frame writes normally.
- Asynchronous `reset` after 2 of 4 imem words → no `imem_we`, `prog_loading`=1, state HDR; `reload` in DONE → `prog_loading`=1, `err`=0, `in_ready`=1.
- Random `in_valid` gaps across a 3-frame stream → write sequence identical to the gap-free run.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared constants for the stream program loader: FSM state codes,
// header field positions and the default pad instruction.
package prog_loader_pkg;

   localparam logic [2:0] ST_HDR   = 3'd0;
   localparam logic [2:0] ST_ADDR  = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_FLUSH = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam int HDR_END_BIT = 31;
   localparam int HDR_TGT_BIT = 30;

   // addi x0,x0,0
   localparam logic [31:0] PAD_WORD_DEF = 32'h0000_0013;

endpackage

// File: rtl/line_packer.sv
// Assembles stream words into imem lines; slot 0 is the most significant word.
// Emits a registered line plus one-cycle line_full strobe when full or flushed.
module line_packer
   import prog_loader_pkg::*;
#(
   parameter int                  WORD_LEN   = 32,
   parameter int                  LINE_WORDS = 4,
   parameter logic [WORD_LEN-1:0] PAD_WORD   = PAD_WORD_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push_i,
   input  logic [WORD_LEN-1:0]            word_i,
   input  logic                           flush_i,
   output logic                           emit_o,
   output logic                           pending_o,
   output logic [LINE_WORDS*WORD_LEN-1:0] line_o,
   output logic                           line_full_o
);

   localparam int LINE_LEN = LINE_WORDS * WORD_LEN;
   localparam int SLOT_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [LINE_LEN-1:0] PAD_LINE = {LINE_WORDS{PAD_WORD}};

   logic [LINE_LEN-1:0] slots_q, slots_d, filled;
   logic [LINE_LEN-1:0] line_q, line_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic                full_q;

   always_comb begin
      slots_d = slots_q;
      slot_d  = slot_q;
      line_d  = line_q;
      emit_o  = 1'b0;
      filled  = slots_q;
      if (push_i) begin
         for (int i = 0; i < LINE_WORDS; i++) begin
            if (slot_q == SLOT_W'(i))
               filled[(LINE_WORDS-1-i)*WORD_LEN +: WORD_LEN] = word_i;
         end
         if (slot_q == SLOT_W'(LINE_WORDS-1)) begin
            emit_o  = 1'b1;
            line_d  = filled;
            slots_d = PAD_LINE;
            slot_d  = '0;
         end else begin
            slots_d = filled;
            slot_d  = slot_q + SLOT_W'(1);
         end
      end else if (flush_i) begin
         // untouched slots already hold the pad word
         emit_o  = 1'b1;
         line_d  = slots_q;
         slots_d = PAD_LINE;
         slot_d  = '0;
      end
   end

   assign pending_o   = (slot_d != '0);
   assign line_o      = line_q;
   assign line_full_o = full_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slots_q <= PAD_LINE;
         slot_q  <= '0;
         line_q  <= '0;
         full_q  <= 1'b0;
      end else begin
         slots_q <= slots_d;
         slot_q  <= slot_d;
         line_q  <= line_d;
         full_q  <= emit_o;
      end
   end

endmodule

// File: rtl/stream_prog_loader.sv
// Parses a header/address/data word stream into imem line and dmem word writes,
// holding the core in prog_loading until an END header is seen.
module stream_prog_loader
   import prog_loader_pkg::*;
#(
   parameter int                  WORD_LEN      = 32,
   parameter int                  LINE_WORDS    = 4,
   parameter int                  ADDR_LEN      = 32,
   parameter int                  IMEM_ADDR_LEN = 9,
   parameter int                  CNT_LEN       = 16,
   parameter logic [WORD_LEN-1:0] PAD_WORD      = PAD_WORD_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic [WORD_LEN-1:0]            in_data,
   output logic                           in_ready,
   input  logic                           reload,
   output logic                           prog_loading,
   output logic                           imem_we,
   output logic [IMEM_ADDR_LEN-1:0]       imem_addr,
   output logic [LINE_WORDS*WORD_LEN-1:0] imem_wdata,
   output logic                           dmem_we,
   output logic [ADDR_LEN-1:0]            dmem_addr,
   output logic [WORD_LEN-1:0]            dmem_wdata,
   output logic                           done,
   output logic                           err
);

   localparam int LINE_SHIFT = $clog2(LINE_WORDS*4);

   logic [2:0]               state_q, state_d;
   logic                     tgt_q, tgt_d;
   logic                     discard_q, discard_d;
   logic [CNT_LEN-1:0]       cnt_q, cnt_d;
   logic [ADDR_LEN-1:0]      waddr_q, waddr_d;
   logic [IMEM_ADDR_LEN-1:0] line_idx_q, line_idx_d;
   logic                     err_q, err_d;
   logic                     dmem_we_q, dmem_we_d;
   logic [ADDR_LEN-1:0]      dmem_addr_q, dmem_addr_d;
   logic [WORD_LEN-1:0]      dmem_wdata_q, dmem_wdata_d;
   logic [IMEM_ADDR_LEN-1:0] imem_addr_q, imem_addr_d;

   logic                acc, push, flush, emit, pending;
   logic [ADDR_LEN-1:0] base;

   assign in_ready = (state_q == ST_HDR) || (state_q == ST_ADDR) || (state_q == ST_DATA);
   assign acc      = in_valid && in_ready;
   assign base     = ADDR_LEN'(in_data);
   assign push     = acc && (state_q == ST_DATA) && !discard_q && !tgt_q;
   assign flush    = (state_q == ST_FLUSH);

   line_packer #(
      .WORD_LEN  (WORD_LEN),
      .LINE_WORDS(LINE_WORDS),
      .PAD_WORD  (PAD_WORD)
   ) u_packer (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push),
      .word_i     (in_data),
      .flush_i    (flush),
      .emit_o     (emit),
      .pending_o  (pending),
      .line_o     (imem_wdata),
      .line_full_o(imem_we)
   );

   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      discard_d    = discard_q;
      cnt_d        = cnt_q;
      waddr_d      = waddr_q;
      line_idx_d   = line_idx_q;
      err_d        = err_q;
      dmem_we_d    = 1'b0;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      imem_addr_d  = imem_addr_q;
      case (state_q)
         ST_HDR: if (acc) begin
            if (in_data[HDR_END_BIT]) begin
               state_d = ST_DONE;
            end else begin
               tgt_d   = in_data[HDR_TGT_BIT];
               cnt_d   = in_data[CNT_LEN-1:0];
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: if (acc) begin
            waddr_d    = base;
            line_idx_d = IMEM_ADDR_LEN'(base >> LINE_SHIFT);
            discard_d  = !tgt_q && (base[LINE_SHIFT-1:0] != '0);
            if (discard_d) err_d = 1'b1;
            state_d = (cnt_q == '0) ? ST_HDR : ST_DATA;
         end
         ST_DATA: if (acc) begin
            cnt_d = cnt_q - CNT_LEN'(1);
            if (tgt_q && !discard_q) begin
               dmem_we_d    = 1'b1;
               dmem_addr_d  = waddr_q;
               dmem_wdata_d = in_data;
               waddr_d      = waddr_q + ADDR_LEN'(4);
            end
            if (cnt_q == CNT_LEN'(1))
               state_d = (push && pending) ? ST_FLUSH : ST_HDR;
         end
         ST_FLUSH: state_d = ST_HDR;
         ST_DONE: if (reload) begin
            state_d = ST_HDR;
            err_d   = 1'b0;
         end
         default: state_d = ST_HDR;
      endcase
      // line index advances with every emitted line, wrapping at IMEM_ADDR_LEN
      if (emit) begin
         imem_addr_d = line_idx_q;
         line_idx_d  = line_idx_q + IMEM_ADDR_LEN'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_HDR;
         tgt_q        <= 1'b0;
         discard_q    <= 1'b0;
         cnt_q        <= '0;
         waddr_q      <= '0;
         line_idx_q   <= '0;
         err_q        <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         imem_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         discard_q    <= discard_d;
         cnt_q        <= cnt_d;
         waddr_q      <= waddr_d;
         line_idx_q   <= line_idx_d;
         err_q        <= err_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         imem_addr_q  <= imem_addr_d;
      end
   end

   assign prog_loading = (state_q != ST_DONE);
   assign done         = (state_q == ST_DONE);
   assign err          = err_q;
   assign dmem_we      = dmem_we_q;
   assign dmem_addr    = dmem_addr_q;
   assign dmem_wdata   = dmem_wdata_q;
   assign imem_addr    = imem_addr_q;

endmodule
